// File: rtl/speaker_arbiter_if.sv
// Speaker arbiter request/response bundle.
// Requesters drive the master side; the arbiter sits on the slave side.
interface speaker_arbiter_if;
    logic       req_alarm;
    logic       req_chime;
    logic [3:0] chime_cnt;
    logic       req_key;
    logic       speaker;
    logic       busy;
    logic [1:0] owner;
    logic       chime_lost;

    modport master (
        output req_alarm, req_chime, chime_cnt, req_key,
        input  speaker, busy, owner, chime_lost
    );

    modport slave (
        input  req_alarm, req_chime, chime_cnt, req_key,
        output speaker, busy, owner, chime_lost
    );
endinterface

// File: rtl/speaker_arbiter.sv
// Fixed-priority owner of the piezo speaker: alarm > chime > key click.
// Times beeps/gaps from a ms tick and synthesises each owner's tone.
module speaker_arbiter #(
    parameter int MS_DIV     = 100000,
    parameter int KEY_MS     = 50,
    parameter int BEEP_MS    = 200,
    parameter int GAP_MS     = 200,
    parameter int KEY_HALF   = 25000,
    parameter int CHIME_HALF = 50000,
    parameter int ALARM_HALF = 20000
) (
    input  logic             clk,
    input  logic             rst,
    speaker_arbiter_if.slave bus
);
    localparam int HMAX0 = (KEY_HALF > CHIME_HALF) ? KEY_HALF : CHIME_HALF;
    localparam int HMAX  = (HMAX0 > ALARM_HALF) ? HMAX0 : ALARM_HALF;
    localparam int MMAX0 = (KEY_MS > BEEP_MS) ? KEY_MS : BEEP_MS;
    localparam int MMAX  = (MMAX0 > GAP_MS) ? MMAX0 : GAP_MS;
    localparam int DW    = $clog2(MS_DIV + 1);
    localparam int TW    = $clog2(HMAX + 1);
    localparam int MW    = $clog2(MMAX + 1);

    typedef enum logic [2:0] {
        IDLE, KEY, CHIME_ON, CHIME_OFF, ALARM_ON, ALARM_OFF
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] div_cnt;
    logic [MW-1:0] ms_cnt;
    logic [TW-1:0] tone_cnt;
    logic [TW-1:0] half;
    logic [MW-1:0] len;
    logic [3:0]    beeps, beeps_nx;
    logic [3:0]    pend_cnt, pend_nx;
    logic [3:0]    new_cnt;
    logic [1:0]    owner_nx;
    logic          new_req, lost, tick, done, enter, tone_on;
    logic          spk_q, busy_q, lost_q;
    logic [1:0]    owner_q;

    assign bus.speaker    = spk_q;
    assign bus.busy       = busy_q;
    assign bus.owner      = owner_q;
    assign bus.chime_lost = lost_q;

    // Per-state tone half-period and interval length in ms.
    always_comb begin
        tone_on = 1'b0;
        half    = '0;
        len     = '0;
        unique case (state)
            KEY: begin
                tone_on = 1'b1;
                half    = TW'(KEY_HALF);
                len     = MW'(KEY_MS);
            end
            CHIME_ON: begin
                tone_on = 1'b1;
                half    = TW'(CHIME_HALF);
                len     = MW'(BEEP_MS);
            end
            ALARM_ON: begin
                tone_on = 1'b1;
                half    = TW'(ALARM_HALF);
                len     = MW'(BEEP_MS);
            end
            CHIME_OFF, ALARM_OFF: len = MW'(GAP_MS);
            default: len = '0;
        endcase
    end

    assign tick  = (div_cnt == DW'(MS_DIV - 1));
    assign done  = tick && (ms_cnt == len - 1'b1);
    assign enter = (state_nx != state);

    // Owner selection, chime latching and lost-chime detection.
    always_comb begin
        state_nx = state;
        beeps_nx = beeps;
        pend_nx  = pend_cnt;
        lost     = 1'b0;
        new_req  = bus.req_chime && (bus.chime_cnt != 4'd0);
        new_cnt  = (bus.chime_cnt > 4'd12) ? 4'd12 : bus.chime_cnt;

        // A chime already playing cannot queue another one.
        if (state == CHIME_ON || state == CHIME_OFF) begin
            lost = new_req;
        end else if (new_req) begin
            lost    = (pend_cnt != 4'd0);
            pend_nx = new_cnt;
        end

        unique case (state)
            IDLE: begin
                if (bus.req_alarm) begin
                    state_nx = ALARM_ON;
                end else if (pend_nx != 4'd0) begin
                    state_nx = CHIME_ON;
                    beeps_nx = pend_nx;
                    pend_nx  = 4'd0;
                end else if (bus.req_key) begin
                    state_nx = KEY;
                end
            end
            KEY: begin
                if (bus.req_alarm) state_nx = ALARM_ON;
                else if (done)     state_nx = IDLE;
            end
            CHIME_ON: begin
                if (bus.req_alarm) begin
                    state_nx = ALARM_ON;
                end else if (done) begin
                    beeps_nx = beeps - 4'd1;
                    state_nx = (beeps > 4'd1) ? CHIME_OFF : IDLE;
                end
            end
            CHIME_OFF: begin
                if (bus.req_alarm) state_nx = ALARM_ON;
                else if (done)     state_nx = CHIME_ON;
            end
            ALARM_ON, ALARM_OFF: begin
                if (!bus.req_alarm) begin
                    if (pend_nx != 4'd0) begin
                        state_nx = CHIME_ON;
                        beeps_nx = pend_nx;
                        pend_nx  = 4'd0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (done) begin
                    state_nx = (state == ALARM_ON) ? ALARM_OFF : ALARM_ON;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Owner code of the state being entered.
    always_comb begin
        unique case (state_nx)
            KEY:                 owner_nx = 2'd1;
            CHIME_ON, CHIME_OFF: owner_nx = 2'd2;
            ALARM_ON, ALARM_OFF: owner_nx = 2'd3;
            default:             owner_nx = 2'd0;
        endcase
    end

    // State, pending chime and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            beeps    <= 4'd0;
            pend_cnt <= 4'd0;
            busy_q   <= 1'b0;
            owner_q  <= 2'd0;
            lost_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            beeps    <= beeps_nx;
            pend_cnt <= pend_nx;
            busy_q   <= (state_nx != IDLE);
            owner_q  <= owner_nx;
            lost_q   <= lost;
        end
    end

    // ms divider and interval counter, restarted on each state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            ms_cnt  <= '0;
        end else if (enter) begin
            div_cnt <= '0;
            ms_cnt  <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) ms_cnt <= ms_cnt + 1'b1;
        end
    end

    // Square-wave tone; silent and phase-reset outside tone states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_cnt <= '0;
            spk_q    <= 1'b0;
        end else if (enter || !tone_on) begin
            tone_cnt <= '0;
            spk_q    <= 1'b0;
        end else if (tone_cnt == half - 1'b1) begin
            tone_cnt <= '0;
            spk_q    <= ~spk_q;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_speaker_arbiter.sv
// Randomised scoreboard bench for speaker_arbiter.
// A session-level model predicts every cycle's outputs.
module tb_speaker_arbiter;
    localparam int MS_DIV     = 10;
    localparam int KEY_MS     = 50;
    localparam int BEEP_MS    = 20;
    localparam int GAP_MS     = 20;
    localparam int KEY_HALF   = 5;
    localparam int CHIME_HALF = 7;
    localparam int ALARM_HALF = 3;
    localparam int B = BEEP_MS * MS_DIV;
    localparam int G = GAP_MS * MS_DIV;
    localparam int P = B + G;
    localparam int K = KEY_MS * MS_DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;

    speaker_arbiter_if bus ();

    speaker_arbiter #(
        .MS_DIV(MS_DIV), .KEY_MS(KEY_MS), .BEEP_MS(BEEP_MS),
        .GAP_MS(GAP_MS), .KEY_HALF(KEY_HALF),
        .CHIME_HALF(CHIME_HALF), .ALARM_HALF(ALARM_HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       spk;
        logic       busy;
        logic [1:0] owner;
        logic       lost;
    } exp_t;

    exp_t q[$];
    exp_t m_exp;
    exp_t mon_ex;
    exp_t mon_got;
    int   n_cmp = 0;
    int   n_err = 0;

    // Session model: owner, cycles since session start, beeps, pending.
    int   m_own, m_e, m_beeps, m_pend, m_new;
    logic m_lost;

    function automatic logic tone(int e, int hp, int on_len, int per);
        int pos;
        pos = e % per;
        if (pos >= on_len) return 1'b0;
        return ((pos / hp) % 2) == 1;
    endfunction

    // Predict post-edge outputs at every clock edge and at reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_own = 0; m_e = 0; m_beeps = 0; m_pend = 0;
            q.delete();
            q.push_back('0);
        end else begin
            m_new = 0;
            if (bus.req_chime && bus.chime_cnt != 0)
                m_new = (bus.chime_cnt > 12) ? 12 : int'(bus.chime_cnt);
            m_lost = 1'b0;
            if (m_own == 2) begin
                m_lost = (m_new != 0);
            end else if (m_new != 0) begin
                m_lost = (m_pend != 0);
                m_pend = m_new;
            end
            case (m_own)
                0: begin
                    if (bus.req_alarm) begin
                        m_own = 3; m_e = 0;
                    end else if (m_pend != 0) begin
                        m_own = 2; m_e = 0; m_beeps = m_pend; m_pend = 0;
                    end else if (bus.req_key) begin
                        m_own = 1; m_e = 0;
                    end
                end
                1: begin
                    if (bus.req_alarm) begin m_own = 3; m_e = 0; end
                    else if (m_e == K - 1) m_own = 0;
                    else m_e++;
                end
                2: begin
                    if (bus.req_alarm) begin m_own = 3; m_e = 0; end
                    else if (m_e == m_beeps * P - G - 1) m_own = 0;
                    else m_e++;
                end
                default: begin
                    if (!bus.req_alarm) begin
                        if (m_pend != 0) begin
                            m_own = 2; m_e = 0; m_beeps = m_pend; m_pend = 0;
                        end else begin
                            m_own = 0;
                        end
                    end else begin
                        m_e++;
                    end
                end
            endcase
            m_exp.owner = 2'(m_own);
            m_exp.busy  = (m_own != 0);
            m_exp.lost  = m_lost;
            case (m_own)
                1:       m_exp.spk = tone(m_e, KEY_HALF, K, K);
                2:       m_exp.spk = tone(m_e, CHIME_HALF, B, P);
                3:       m_exp.spk = tone(m_e, ALARM_HALF, B, P);
                default: m_exp.spk = 1'b0;
            endcase
            q.push_back(m_exp);
        end
    end

    // Monitor: compare DUT outputs with the predicted entry each cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_ex  = q.pop_front();
            mon_got = {bus.speaker, bus.busy, bus.owner, bus.chime_lost};
            n_cmp++;
            if (mon_got !== mon_ex) begin
                n_err++;
                if (n_err <= 20)
                    $display("FAIL cycle t=%0t got spk=%b busy=%b own=%0d lost=%b required spk=%b busy=%b own=%0d lost=%b",
                             $time, mon_got.spk, mon_got.busy, mon_got.owner, mon_got.lost,
                             mon_ex.spk, mon_ex.busy, mon_ex.owner, mon_ex.lost);
            end
        end
    end

    task automatic chk(string nm, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d required=%0d", nm, got, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_chime(int c);
        bus.req_chime = 1'b1;
        bus.chime_cnt = 4'(c);
        cyc(1);
        bus.req_chime = 1'b0;
        bus.chime_cnt = 4'd0;
    endtask

    task automatic pulse_key();
        bus.req_key = 1'b1;
        cyc(1);
        bus.req_key = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.busy) begin
            n_err++;
            $display("FAIL wait_idle timeout got busy=1 required busy=0");
        end
        cyc(1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1);
    end

    initial begin
        int r, n;
        bus.req_alarm = 1'b0;
        bus.req_chime = 1'b0;
        bus.chime_cnt = 4'd0;
        bus.req_key   = 1'b0;
        cyc(3);
        @(negedge clk);
        chk("rst_owner", int'(bus.owner), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_speaker", int'(bus.speaker), 0);
        cyc(1);
        rst = 1'b1;
        cyc(2);

        // Key click
        pulse_key();
        @(negedge clk);
        chk("key_owner", int'(bus.owner), 1);
        chk("key_busy", int'(bus.busy), 1);
        wait_idle(K + 50);
        chk("key_end_owner", int'(bus.owner), 0);
        chk("key_end_spk", int'(bus.speaker), 0);

        // Three-beep chime, then a zero-count request
        pulse_chime(3);
        @(negedge clk);
        chk("chime_owner", int'(bus.owner), 2);
        wait_idle(3 * P + 50);
        pulse_chime(0);
        @(negedge clk);
        chk("chime0_busy", int'(bus.busy), 0);
        cyc(20);

        // Alarm preempts beep 2; chime not resumed
        pulse_chime(3);
        cyc(P + $urandom_range(10, B - 10));
        bus.req_alarm = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("preempt_owner", int'(bus.owner), 3);
        cyc($urandom_range(300, 900));
        bus.req_alarm = 1'b0;
        wait_idle(20);
        chk("no_resume_owner", int'(bus.owner), 0);

        // Clamp 15 to 12 beeps
        pulse_chime(15);
        wait_idle(12 * P + 50);

        // Pending chime behind alarm, replaced by a newer one
        bus.req_alarm = 1'b1;
        cyc(5);
        pulse_chime(2);
        cyc(30);
        pulse_chime($urandom_range(1, 4));
        @(negedge clk);
        chk("replace_lost", int'(bus.chime_lost), 1);
        cyc($urandom_range(50, 400));
        bus.req_alarm = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("pend_owner", int'(bus.owner), 2);
        wait_idle(4 * P + 50);

        // Chime and key together; key during chime
        bus.req_chime = 1'b1;
        bus.chime_cnt = 4'd1;
        bus.req_key   = 1'b1;
        cyc(1);
        bus.req_chime = 1'b0;
        bus.chime_cnt = 4'd0;
        bus.req_key   = 1'b0;
        @(negedge clk);
        chk("tie_owner", int'(bus.owner), 2);
        cyc(50);
        pulse_key();
        wait_idle(P + 50);

        // Async reset while alarm tone is high
        bus.req_alarm = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.speaker && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("alarm_spk_high", int'(bus.speaker), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_spk", int'(bus.speaker), 0);
        chk("async_owner", int'(bus.owner), 0);
        chk("async_busy", int'(bus.busy), 0);
        bus.req_alarm = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(20);
        @(negedge clk);
        chk("post_rst_idle", int'(bus.owner), 0);
        cyc(1);
        bus.req_alarm = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("post_rst_alarm", int'(bus.owner), 3);
        cyc(1);
        bus.req_alarm = 1'b0;
        cyc(5);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25) begin
                pulse_key();
            end else if (r < 50) begin
                pulse_chime($urandom_range(0, 5));
            end else if (r < 65) begin
                bus.req_alarm = ~bus.req_alarm;
            end else if (r < 72) begin
                bus.req_chime = 1'b1;
                bus.chime_cnt = 4'($urandom_range(0, 15));
                bus.req_key   = 1'b1;
                cyc(1);
                bus.req_chime = 1'b0;
                bus.chime_cnt = 4'd0;
                bus.req_key   = 1'b0;
            end
            cyc($urandom_range(1, 500));
        end
        bus.req_alarm = 1'b0;
        wait_idle(12 * P + K + 100);
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/speaker_arbiter.md
Name: speaker_arbiter

Overview:
Owns the single piezo speaker output and shares it between three requesters: alarm (level), hourly chime (pulse plus beep count) and key click (pulse).
A fixed-priority FSM selects the owner and times on/off intervals from a millisecond tick derived from clk.
It synthesises the square-wave tone for each owner.
It sits between the hour-check/alarm-compare logic and the board speaker pin, replacing the direct speaker drive.

Parameters:
MS_DIV, 100000, clk cycles per 1 ms tick (100 MHz board clock)
KEY_MS, 50, key click duration in ms
BEEP_MS, 200, chime/alarm beep on-time in ms
GAP_MS, 200, chime/alarm silence between beeps in ms
KEY_HALF, 25000, key tone half-period in clk cycles (2 kHz)
CHIME_HALF, 50000, chime tone half-period in clk cycles (1 kHz)
ALARM_HALF, 20000, alarm tone half-period in clk cycles (2.5 kHz)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
req_alarm  input  1  level; alarm active while high
req_chime  input  1  one-cycle pulse; hourly chime request
chime_cnt  input  4  beep count, sampled with req_chime
req_key  input  1  one-cycle pulse; key click request
speaker  output  1  tone output to speaker pin
busy  output  1  high whenever state is not IDLE
owner  output  2  0 none, 1 key, 2 chime, 3 alarm
chime_lost  output  1  one-cycle pulse when a chime request is dropped

Behaviour:
- Reset (rst low, any time, asynchronous): state IDLE; speaker=0, busy=0, owner=0, chime_lost=0; tick, ms, tone and beep counters cleared; pending chime cleared.
- ms tick: free-running divider pulses once every MS_DIV cycles. It restarts from 0 on every state entry, so the first interval is exactly its full length in ms.
- Tone generator: half-period counter toggles speaker every *_HALF cycles of the current owner. The counter and speaker clear to 0 on every state entry. speaker is forced 0 in IDLE and in all gap states.
- chime_cnt handling: 0 means the request is ignored, with no chime_lost pulse. Values above 12 are clamped to 12.
- States:
  - IDLE: checks in priority order, decided on the same cycle, entry takes effect next cycle.
    - req_alarm high -> ALARM_ON.
    - else pending chime or req_chime -> CHIME_ON, loading the beep count.
    - else req_key -> KEY.
  - KEY (owner 1): tone KEY_HALF for KEY_MS ticks, then IDLE.
  - CHIME_ON (owner 2): tone CHIME_HALF for BEEP_MS ticks, then decrement beeps. Go to CHIME_OFF if beeps remain, else IDLE.
  - CHIME_OFF (owner 2): silent for GAP_MS ticks, then CHIME_ON.
  - ALARM_ON / ALARM_OFF (owner 3): tone ALARM_HALF for BEEP_MS, then silent for GAP_MS, repeating while req_alarm is high.
    - When req_alarm drops, exit the next cycle. Exit goes to CHIME_ON if a chime is pending, else IDLE.
- Preemption and latching:
  - req_alarm high in KEY or CHIME_*: abort next cycle and enter ALARM_ON. An aborted chime is discarded, not resumed.
  - req_chime during KEY or ALARM_*: latched as pending with its count. It plays after the current owner finishes.
  - req_chime while a pending chime already exists: the newer request replaces the pending one and chime_lost pulses.
  - req_chime while in CHIME_*: dropped, and chime_lost pulses.
  - req_key while not IDLE: dropped silently. A key request is never queued.
- Simultaneous events in IDLE:
  - req_chime and req_key together: chime wins, key dropped.
  - req_alarm and req_chime together: alarm wins, chime latched pending.
- busy/owner are registered and update on the same edge as the state.

Test Plan:
1. MS_DIV=10, KEY_HALF=5. rst low then high, pulse req_key. Required: owner=1 and busy=1 the next cycle. speaker toggles every 5 cycles for 500 cycles, then owner=0, busy=0, speaker=0.
2. MS_DIV=10, BEEP_MS=GAP_MS=20. req_chime with chime_cnt=3. Required: exactly 3 bursts of 200 cycles separated by 2 gaps of 200 cycles with speaker=0, then IDLE. chime_cnt=0: no activity.
3. During beep 2 of a 3-beep chime, raise req_alarm. Required: owner=3 next cycle and the chime is not resumed after req_alarm drops (IDLE). chime_cnt=15 clamps to 12 bursts.
4. With req_alarm high, pulse req_chime with chime_cnt=2, then drop req_alarm. Required: owner goes 3->2 and 2 bursts play. A second req_chime while the first is pending yields a chime_lost pulse, and the second count is played.
5. req_chime and req_key pulsed in the same cycle in IDLE. Required: owner=2 and the key is never played. req_key during a chime: no effect.
6. Assert rst low mid-ALARM_ON with speaker=1. Required: speaker=0, owner=0, busy=0 immediately (asynchronously). After release, the block stays IDLE until req_alarm is sampled high.
